// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encodings,
// instruction width and the default NOP encoding.
package if_fetch_pkg;

  localparam int unsigned InstWidth = 32;

  // addi x0, x0, 0
  localparam logic [InstWidth-1:0] NopInst = 32'h0000_0013;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding memory request, one-entry skid for stalls,
// jump redirect with response dropping. Optional counter under IF_FETCH_PERF_CNT_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [InstWidth-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [InstWidth-1:0] NOP_INST = NopInst
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 jump_en_i,
  input  logic [InstWidth-1:0] jump_addr_i,
  input  logic                 hold_i,
  output logic                 imem_req_o,
  output logic [InstWidth-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [InstWidth-1:0] imem_rdata_i,
  output logic [InstWidth-1:0] inst_o,
  output logic [InstWidth-1:0] inst_addr_o,
  output logic                 inst_valid_o,
  output logic [31:0]          fetch_cnt_o
);

  logic [1:0]           state_q, state_d;
  logic [InstWidth-1:0] pc_q, pc_d;
  logic [InstWidth-1:0] skid_q, skid_d;
  logic                 drop_q, drop_d;
  logic [InstWidth-1:0] inst_q, inst_d;
  logic [InstWidth-1:0] inst_addr_q, inst_addr_d;
  logic                 valid_q, valid_d;
  logic                 present;
  logic [InstWidth-1:0] present_data;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_d       = skid_q;
    drop_d       = drop_q;
    present      = 1'b0;
    present_data = imem_rdata_i;

    case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (imem_gnt_i) state_d = StWait;
      end
      StWait: begin
        if (imem_rvalid_i) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else if (hold_i) begin
            skid_d  = imem_rdata_i;
            state_d = StHold;
          end else begin
            present = 1'b1;
            state_d = StReq;
          end
        end
      end
      StHold: begin
        if (!hold_i) begin
          present      = 1'b1;
          present_data = skid_q;
          skid_d       = '0;
          state_d      = StReq;
        end
      end
      default: state_d = StIdle;
    endcase

    if (present) pc_d = pc_q + 32'd4;

    // A redirect overrides everything; an in-flight response must be dropped on arrival.
    if (jump_en_i) begin
      present = 1'b0;
      pc_d    = jump_addr_i & ~32'h3;
      skid_d  = '0;
      drop_d  = 1'b0;
      state_d = StReq;
      if ((state_q == StReq && imem_gnt_i) || (state_q == StWait && !imem_rvalid_i)) begin
        drop_d  = 1'b1;
        state_d = StWait;
      end
    end
  end

  always_comb begin
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    valid_d     = valid_q;
    if (jump_en_i) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      if (present) begin
        inst_d      = present_data;
        inst_addr_d = pc_q;
        valid_d     = 1'b1;
      end else begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      skid_q      <= '0;
      drop_q      <= 1'b0;
      inst_q      <= NOP_INST;
      inst_addr_q <= RESET_PC;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      skid_q      <= skid_d;
      drop_q      <= drop_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_req_o   = (state_q == StReq);
  assign imem_addr_o  = pc_q;
  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;
  assign inst_valid_o = valid_q;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (present && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = cnt_q;
`else
  assign fetch_cnt_o = 32'h0;
`endif

endmodule
